// File: rtl/sap_mem.sv
// sap_mem: SAP-style bus RAM with power-up clear sweep and handshaked program loader.
// Define SAP_MEM_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module sap_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr_en,
  input  logic              re_en,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              prg_mode,
  input  logic              prg_valid,
  input  logic [DATA_W-1:0] prg_data,
  output logic              prg_ready,
  output logic [ADDR_W-1:0] prg_ptr,
  output logic              prg_done,
  output logic              busy,
  output logic              parity_err
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {CLEAR, RUN, PROG} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ptr_nx;
  logic              done_nx;
  always_comb begin
    state_nx = state == CLEAR ? (prg_ptr == '1 ? RUN : CLEAR) : (prg_mode ? PROG : RUN);
    we       = state == CLEAR || (state == RUN && wr_en && !re_en) || (state == PROG && prg_valid);
    waddr    = state == RUN ? address : prg_ptr;
    wdata    = state == RUN ? bus : (state == PROG ? prg_data : '0);
    ptr_nx   = state == CLEAR ? prg_ptr + 1'b1
             : (state == PROG && prg_mode) ? prg_ptr + ADDR_W'(prg_valid) : '0;
    done_nx  = state == PROG && prg_mode && (prg_done || (prg_valid && prg_ptr == '1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      prg_ptr  <= '0;
      prg_done <= 1'b0;
    end else begin
      state    <= state_nx;
      prg_ptr  <= ptr_nx;
      prg_done <= done_nx;
    end
  end
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign bus       = (state == RUN && re_en) ? mem[address] : 'z;
  assign busy      = state == CLEAR;
  assign prg_ready = state == PROG;
`ifdef SAP_MEM_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk) if (we) par[waddr] <= ^wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (state == RUN && re_en) parity_err <= par[address] ^ (^mem[address]);
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sap_mem.sv
// tb_sap_mem: vector table plus scoreboard queue for sap_mem (default DATA_W=8, ADDR_W=4).
module tb_sap_mem;
  localparam int DW = 8;
  localparam int AW = 4;
  logic          clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] address = '0;
  logic          wr_en = 1'b0, re_en = 1'b0, prg_mode = 1'b0, prg_valid = 1'b0;
  logic [DW-1:0] prg_data = '0, bus_drv = '0;
  logic          bus_oe = 1'b0;
  wire  [DW-1:0] bus;
  logic          prg_ready, prg_done, busy, parity_err;
  logic [AW-1:0] prg_ptr;
  assign bus = bus_oe ? bus_drv : 'z;
  always #5 clk = ~clk;
  sap_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .address(address), .wr_en(wr_en), .re_en(re_en), .bus(bus),
    .prg_mode(prg_mode), .prg_valid(prg_valid), .prg_data(prg_data), .prg_ready(prg_ready),
    .prg_ptr(prg_ptr), .prg_done(prg_done), .busy(busy), .parity_err(parity_err)
  );
  int checks = 0, errors = 0;
  typedef struct {string name; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  typedef struct {logic wr, re; logic [AW-1:0] a; logic [DW-1:0] d; logic oe, chk; logic [DW-1:0] exp;} vec_t;
  vec_t vt[10];
  logic [DW-1:0] model [16];
  function automatic vec_t mk(bit wr, bit re, int a, int d, bit oe, bit chk, int exp);
    mk = '{wr, re, AW'(a), DW'(d), oe, chk, DW'(exp)};
  endfunction
  task automatic expect_val(string name, logic [31:0] exp);
    sb.push_back('{name, exp});
  endtask
  task automatic compare(logic [31:0] act);
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    expect_val(name, exp);
    compare(act);
  endtask
  task automatic read_chk(string name, logic [AW-1:0] a, logic [DW-1:0] exp);
    address = a;
    re_en = 1'b1;
    bus_oe = 1'b0;
    expect_val(name, 32'(exp));
    #1 compare(32'(bus));
    tick();
    re_en = 1'b0;
  endtask
  task automatic sweep_chk(string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'd16);
  endtask
  initial begin
    vt[0] = mk(1, 0, 3, 'hA5, 1, 0, 0);
    vt[1] = mk(0, 1, 3, 0, 0, 1, 'hA5);
    vt[2] = mk(1, 1, 3, 'h11, 1, 0, 0);
    vt[3] = mk(0, 1, 3, 0, 0, 1, 'hA5);
    vt[4] = mk(1, 0, 9, 'h3C, 1, 0, 0);
    vt[5] = mk(1, 0, 0, 'hFF, 1, 0, 0);
    vt[6] = mk(0, 1, 9, 0, 0, 1, 'h3C);
    vt[7] = mk(0, 1, 0, 0, 0, 1, 'hFF);
    vt[8] = mk(1, 0, 15, 'h5A, 1, 0, 0);
    vt[9] = mk(0, 1, 15, 0, 0, 1, 'h5A);
    #1;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(prg_ready), 0);
    chk("rst_done", 32'(prg_done), 0);
    chk("rst_ptr", 32'(prg_ptr), 0);
    chk("rst_parity", 32'(parity_err), 0);
    tick();
    tick();
    rst = 1'b0;
    sweep_chk("sweep_cycles");
    for (int a = 0; a < 16; a++) read_chk("clear_read", AW'(a), 8'h00);
    for (int i = 0; i < 10; i++) begin
      wr_en = vt[i].wr;
      re_en = vt[i].re;
      address = vt[i].a;
      bus_drv = vt[i].d;
      bus_oe = vt[i].oe;
      if (vt[i].chk) expect_val("run_vec", 32'(vt[i].exp));
      #1;
      if (vt[i].chk) compare(32'(bus));
      tick();
      wr_en = 1'b0;
      re_en = 1'b0;
      bus_oe = 1'b0;
    end
    prg_mode = 1'b1;
    tick();
    chk("prog_ready", 32'(prg_ready), 1);
    for (int i = 0; i < 16; i++) begin
      prg_valid = 1'b1;
      prg_data = DW'(8'h10 + i);
      model[i] = prg_data;
      tick();
      if (i == 4) chk("load_ptr5", 32'(prg_ptr), 5);
      if (i == 14) chk("load_done_early", 32'(prg_done), 0);
    end
    chk("load_done", 32'(prg_done), 1);
    chk("load_ptr_wrap", 32'(prg_ptr), 0);
    prg_valid = 1'b0;
    prg_mode = 1'b0;
    tick();
    chk("exit_ready", 32'(prg_ready), 0);
    chk("exit_done", 32'(prg_done), 0);
    read_chk("load_word7", 4'd7, 8'h17);
    prg_mode = 1'b1;
    tick();
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        prg_valid = (i % 2) == 0;
        prg_data = DW'(8'h80 + i);
        wr_en = 1'b1;
        address = AW'(i);
        bus_drv = 8'hEE;
        bus_oe = 1'b1;
        tick();
        if ((i % 2) == 0) begin
          model[cnt] = DW'(8'h80 + i);
          cnt++;
        end
        chk("toggle_ptr", 32'(prg_ptr), 32'(cnt));
      end
    end
    prg_valid = 1'b0;
    wr_en = 1'b0;
    bus_oe = 1'b0;
    prg_mode = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) read_chk("toggle_read", AW'(a), model[a]);
    prg_mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      prg_valid = 1'b1;
      prg_data = DW'(8'h40 + i);
      tick();
    end
    prg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midload_busy", 32'(busy), 1);
    chk("midload_ptr", 32'(prg_ptr), 0);
    chk("midload_ready", 32'(prg_ready), 0);
    prg_mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sweep_chk("resweep_cycles");
    read_chk("resweep_word2", 4'd2, 8'h00);
`ifdef SAP_MEM_PARITY_EN
    read_chk("par_setup", 4'd5, 8'h00);
    dut.mem[5] = dut.mem[5] ^ 8'h01;
    address = 4'd5;
    re_en = 1'b1;
    tick();
    chk("parity_bad", 32'(parity_err), 1);
    address = 4'd4;
    tick();
    chk("parity_clean", 32'(parity_err), 0);
    re_en = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap_mem.md
# sap_mem

Parametrised main memory for the SAP-style CPU, replacing the fixed 16x8 RAM. It sits on the shared tri-state data bus: it drives the bus on a read strobe and captures it on a write strobe. A handshaked program-loader port streams an image into consecutive words from address 0. After reset the block clears every word to zero before accepting any access.

## Interface
Parameters:
- `DATA_W`, 8, word and bus width.
- `ADDR_W`, 4, address width; depth is the derived local value `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address`  in  ADDR_W  word address for bus accesses.
- `wr_en`  in  1  bus write strobe.
- `re_en`  in  1  bus read strobe.
- `bus`  inout  DATA_W  shared data bus.
- `prg_mode`  in  1  selects program-load mode.
- `prg_valid`  in  1  loader has a word on `prg_data`.
- `prg_data`  in  DATA_W  loader word.
- `prg_ready`  out  1  block accepts a loader word this cycle.
- `prg_ptr`  out  ADDR_W  next loader write address.
- `prg_done`  out  1  sticky flag: the full image has been written.
- `busy`  out  1  clear sweep in progress.
- `parity_err`  out  1  parity mismatch on the last read (see Configuration).

## Operation
- States: CLEAR, RUN, PROG.
- CLEAR:
  - Writes zero to `mem[prg_ptr]` and increments `prg_ptr` each cycle.
  - After the write to word DEPTH-1 it moves to RUN and `prg_ptr` wraps to 0.
  - `busy`=1 throughout. Bus strobes and loader are ignored, and `bus` is Z.
- RUN:
  - `bus` = `mem[address]` combinationally while `re_en`=1, otherwise Z.
  - Write on `clk` rise when `wr_en`=1 and `re_en`=0: `mem[address]` <= `bus`.
  - If `wr_en` and `re_en` are both 1, the write is suppressed and the read wins.
  - `prg_mode`=1 at a clock edge moves the block to PROG.
- PROG:
  - `prg_ready`=1, and `bus` is Z.
  - Bus strobes are ignored.
  - On `prg_valid` & `prg_ready`: `mem[prg_ptr]` <= `prg_data`, then `prg_ptr`++.
  - Writing word DEPTH-1 sets `prg_done` and wraps `prg_ptr` to 0. Further words overwrite from 0 and `prg_done` stays 1.
  - `prg_mode`=0 at a clock edge returns the block to RUN, clears `prg_ptr` and `prg_done`, and drops `prg_ready`, all in the same edge.
- Pointer arithmetic is modulo DEPTH, using the natural ADDR_W wrap.

## Timing
- Reset values: state=CLEAR, `prg_ptr`=0, `busy`=1, `prg_ready`=0, `prg_done`=0, `parity_err`=0, `bus`=Z.
- Clear sweep: DEPTH cycles after `rst` falls. `busy` drops at the edge that completes word DEPTH-1, so the first RUN access is possible at cycle DEPTH.
- `rst` asserted mid-sweep or mid-load:
  - Restarts CLEAR immediately.
  - Memory contents are not guaranteed until the sweep completes.
- Read latency is 0 cycles (combinational). Write latency is 1 edge: the data is readable the cycle after the write edge.
- RUN→PROG takes 1 edge. `prg_ready` is first high in the cycle after the edge that sampled `prg_mode`=1.
- `prg_mode`=1 held through CLEAR: PROG is entered on the edge after the sweep completes.

## Configuration
- `SAP_MEM_PARITY_EN` defined:
  - Each word stores one extra even-parity bit, computed on every write: bus, loader and clear (parity of zero = 0).
  - On each clock edge with a RUN read (`re_en`=1), `parity_err` registers the mismatch between stored and recomputed parity; it holds until the next read.
- Not defined: there is no parity storage, and `parity_err` is tied to 0.

## Test plan
- Release reset and hold `re_en`=0 → `busy`=1 for exactly 16 cycles (default params). Then reading every address drives `8'h00`.
- RUN: bus=`8'hA5` with `wr_en` at address 3, then `re_en` at address 3 → bus=`8'hA5`. Assert both strobes with bus forced to `8'h11` → address 3 still reads `8'hA5`.
- PROG: stream 16 words `8'h10`..`8'h1F` with `prg_valid` stuck at 1 → `prg_done` rises after the 16th accept and `prg_ptr`=0. Drop `prg_mode` → address 7 reads `8'h17` and `prg_done`=0.
- PROG: toggle `prg_valid` 1/0 and pulse `wr_en` → only valid beats are written, `prg_ptr` advances once per beat, and bus writes have no effect.
- Assert `rst` after 5 loader words → `busy`=1 and `prg_ptr`=0. After 16 cycles, address 2 reads `8'h00`.
- With `SAP_MEM_PARITY_EN`: force-flip a stored data bit by backdoor, then read → `parity_err`=1 next cycle. A read of a clean word → `parity_err`=0.
